dht11_responder: RTL and testbench
==================================

// Module: dht11_responder
// PURPOSE
//  DHT11 sensor emulator: the responder end of the one-wire DHT11 protocol.
//  - Detects the host start pulse, then returns a 40-bit frame with datasheet timing:
//    hum, humd, tem, temd, checksum.
//  - Used as bench/board stand-in for the physical sensor, opposite the DHT11 host reader.
//  - clk is a 1 us tick (1 MHz); all timing parameters are in clk cycles (= us).
// PARAMETERS
//  START_MIN  16000  min host low time (cycles) accepted as a valid start request
//  RESP_WAIT  30     delay after host release before responder pulls low
//  RESP_LOW   80     response low phase
//  RESP_HIGH  80     response released (high) phase
//  BIT_LOW    50     low preamble before every data bit, and final end-of-frame low
//  BIT0_HIGH  26     released time encoding a '0'
//  BIT1_HIGH  70     released time encoding a '1'
//  HOLDOFF    1000   cycles line is ignored after a frame before a new start is accepted
// PORTS
//  clk         in   1  1 MHz clock
//  reset       in   1  synchronous, active-high reset
//  line_in     in   1  sampled onewire level (async; synchronised internally)
//  drive_low   out  1  1 = pull onewire low; top level: onewire = drive_low ? 1'b0 : 1'bz
//  hum         in   8  humidity integer byte to report
//  humd        in   8  humidity decimal byte
//  tem         in   8  temperature integer byte
//  temd        in   8  temperature decimal byte
//  busy        out  1  1 from valid start detection until HOLDOFF done
//  frame_done  out  1  1-cycle pulse when the end-of-frame low is released
//  err_short   out  1  1-cycle pulse when host low ends before START_MIN
// BEHAVIOUR
//  - Reset: drive_low=0, busy=0, frame_done=0, err_short=0, state IDLE, counters 0.
//    Reset mid-frame releases the line on the next edge.
//  - line_in passes a 2-flop synchroniser (ls); all edge detection uses ls.
//    Fixed 2-cycle input latency.
//  - IDLE: ls falling edge -> START_LOW, cnt=0.
//  - START_LOW: cnt++ (saturate) while ls==0. On ls rising edge:
//    - cnt>=START_MIN -> WAIT_REL, busy=1.
//    - else err_short pulse, go IDLE.
//  - WAIT_REL: count RESP_WAIT cycles -> RESP_L.
//    On entry, latch hum/humd/tem/temd and sum=(hum+humd+tem+temd) mod 256 into a 40-bit shift reg.
//    Input changes after the latch do not affect the frame.
//  - RESP_L: drive_low=1 for RESP_LOW cycles -> RESP_H.
//  - RESP_H: drive_low=0 for RESP_HIGH cycles -> BIT_L, bitcnt=0.
//  - BIT_L: drive_low=1 for BIT_LOW cycles -> BIT_H.
//  - BIT_H: drive_low=0 for BIT1_HIGH if shreg[39] else BIT0_HIGH cycles. Then shift left, bitcnt++.
//    - bitcnt==39 -> END_L.
//    - else BIT_L.
//  - Bit order: MSB first, hum[7] .. sum[0].
//  - END_L: drive_low=1 for BIT_LOW cycles, then release, frame_done pulse -> HOLD.
//  - HOLD: count HOLDOFF cycles ignoring ls -> IDLE, busy=0.
//  - From WAIT_REL to END_L, ls is ignored: no collision checking, and a host pulling low does not abort.
//  - Every phase length is exact: phase N lasts precisely its parameter in cycles, with no +1 slop.
//  - Total frame (RESP_L start to END_L release) = 160 + 40*50 + sum(bit highs) + 50 cycles.
// CONFIGURATION
//  CHECKSUM_CORRUPT_EN defined:
//  - adds input port corrupt_sum (1 bit), sampled at the WAIT_REL latch.
//  - When 1, the transmitted checksum LSB is inverted, for host error-path injection.
//  Undefined: no port; checksum is always correct.
// TESTING
//  - hum=45,humd=0,tem=23,temd=0, host low 18000 then release:
//    drive_low low 80 / high 80 at +30 after release; 40 bits decode 0x2D,0x00,0x17,0x00,0x44; frame_done once.
//  - Host low 500 cycles: err_short pulses once, drive_low stays 0, busy stays 0.
//  - hum=0xFF,humd=0xFF,tem=0xFF,temd=0xFF: checksum wraps to 0xFC; all 32 data bits high phases = 70.
//  - Change hum mid-frame 0x10->0x20: transmitted hum remains 0x10; next frame after HOLDOFF sends 0x20.
//  - Assert reset during bit 12: drive_low=0 next edge, busy=0; subsequent 18000 start yields full correct frame.
//  - CHECKSUM_CORRUPT_EN, corrupt_sum=1, first scenario: checksum sent 0x45, data bytes unchanged.

Source files
------------

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with a 40-bit humidity/temperature frame.
// Optional CHECKSUM_CORRUPT_EN adds corrupt_sum, which inverts the transmitted checksum LSB.
module dht11_responder #(
  parameter int START_MIN = 16000,
  parameter int RESP_WAIT = 30,
  parameter int RESP_LOW  = 80,
  parameter int RESP_HIGH = 80,
  parameter int BIT_LOW   = 50,
  parameter int BIT0_HIGH = 26,
  parameter int BIT1_HIGH = 70,
  parameter int HOLDOFF   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_in,
  output logic       drive_low,
  input  logic [7:0] hum,
  input  logic [7:0] humd,
  input  logic [7:0] tem,
  input  logic [7:0] temd,
`ifdef CHECKSUM_CORRUPT_EN
  input  logic       corrupt_sum,
`endif
  output logic       busy,
  output logic       frame_done,
  output logic       err_short
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] START_LOW = 4'd1;
  localparam logic [3:0] WAIT_REL  = 4'd2;
  localparam logic [3:0] RESP_L    = 4'd3;
  localparam logic [3:0] RESP_H    = 4'd4;
  localparam logic [3:0] BIT_L     = 4'd5;
  localparam logic [3:0] BIT_H     = 4'd6;
  localparam logic [3:0] END_L     = 4'd7;
  localparam logic [3:0] HOLD      = 4'd8;

  // Phase counter runs 0..LEN-1, so each phase occupies exactly LEN cycles.
  localparam logic [15:0] WAIT_END  = 16'(RESP_WAIT - 1);
  localparam logic [15:0] RLOW_END  = 16'(RESP_LOW - 1);
  localparam logic [15:0] RHIGH_END = 16'(RESP_HIGH - 1);
  localparam logic [15:0] BLOW_END  = 16'(BIT_LOW - 1);
  localparam logic [15:0] B0_END    = 16'(BIT0_HIGH - 1);
  localparam logic [15:0] B1_END    = 16'(BIT1_HIGH - 1);
  localparam logic [15:0] HOLD_END  = 16'(HOLDOFF - 1);
  localparam logic [15:0] SMIN      = 16'(START_MIN);

  logic [3:0]  state;
  logic [15:0] cnt;
  logic [5:0]  bitcnt;
  logic [39:0] shreg;
  logic        s1, ls, ls_d;
  logic [7:0]  sum;
  logic        flip;

`ifdef CHECKSUM_CORRUPT_EN
  assign flip = corrupt_sum;
`else
  assign flip = 1'b0;
`endif

  assign sum       = hum + humd + tem + temd;
  assign drive_low = (state == RESP_L) || (state == BIT_L) || (state == END_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser resets to the idle (pulled-up) level so reset release is not seen as a fall.
      s1         <= 1'b1;
      ls         <= 1'b1;
      ls_d       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      s1         <= line_in;
      ls         <= s1;
      ls_d       <= ls;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      case (state)
        IDLE: if (ls_d && !ls) begin
          state <= START_LOW;
          cnt   <= '0;
        end
        START_LOW: begin
          if (!ls) begin
            if (cnt != '1) cnt <= cnt + 16'd1;
          end else if (cnt >= SMIN) begin
            state <= WAIT_REL;
            cnt   <= '0;
            busy  <= 1'b1;
            shreg <= {hum, humd, tem, temd, sum ^ {7'd0, flip}};
          end else begin
            state     <= IDLE;
            err_short <= 1'b1;
          end
        end
        WAIT_REL: if (cnt == WAIT_END) begin
          state <= RESP_L;
          cnt   <= '0;
        end else cnt <= cnt + 16'd1;
        RESP_L: if (cnt == RLOW_END) begin
          state <= RESP_H;
          cnt   <= '0;
        end else cnt <= cnt + 16'd1;
        RESP_H: if (cnt == RHIGH_END) begin
          state  <= BIT_L;
          cnt    <= '0;
          bitcnt <= '0;
        end else cnt <= cnt + 16'd1;
        BIT_L: if (cnt == BLOW_END) begin
          state <= BIT_H;
          cnt   <= '0;
        end else cnt <= cnt + 16'd1;
        BIT_H: if (cnt == (shreg[39] ? B1_END : B0_END)) begin
          shreg  <= {shreg[38:0], 1'b0};
          bitcnt <= bitcnt + 6'd1;
          cnt    <= '0;
          state  <= (bitcnt == 6'd39) ? END_L : BIT_L;
        end else cnt <= cnt + 16'd1;
        END_L: if (cnt == BLOW_END) begin
          state      <= HOLD;
          cnt        <= '0;
          frame_done <= 1'b1;
        end else cnt <= cnt + 16'd1;
        HOLD: if (cnt == HOLD_END) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: drives host start pulses and decodes the returned frame by pulse widths.
module tb_dht11_responder;
  localparam int START_MIN = 400;
  localparam int HOST_LOW  = 450;
  localparam int RESP_WAIT = 30;
  localparam int HOLDOFF   = 1000;
  // Release to first low: 2 synchroniser flops plus the edge that detects the release.
  localparam int REL_LAT   = RESP_WAIT + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_in;
  logic       drive_low;
  logic [7:0] hum, humd, tem, temd;
  logic       busy, frame_done, err_short;
`ifdef CHECKSUM_CORRUPT_EN
  logic       corrupt_sum;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dht11_responder #(.START_MIN(START_MIN), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .line_in(line_in), .drive_low(drive_low),
    .hum(hum), .humd(humd), .tem(tem), .temd(temd),
`ifdef CHECKSUM_CORRUPT_EN
    .corrupt_sum(corrupt_sum),
`endif
    .busy(busy), .frame_done(frame_done), .err_short(err_short)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: bytes in transmit order, checksum is the byte sum mod 256.
  function automatic logic [39:0] model(input int h, input int hd, input int t, input int td, input bit c);
    int s;
    s = (h + hd + t + td) % 256;
    if (c) s = s ^ 1;
    return {8'(h), 8'(hd), 8'(t), 8'(td), 8'(s)};
  endfunction

  // Length of the drive_low run at the current level, current sample included.
  task automatic run(input logic lvl, output int len);
    len = 1;
    tick();
    while (drive_low === lvl && len < 20000) begin
      len++;
      tick();
    end
  endtask

  task automatic set_data(input int h, input int hd, input int t, input int td);
    hum = 8'(h); humd = 8'(hd); tem = 8'(t); temd = 8'(td);
  endtask

  // Receive one frame after the host release, checking every phase width and the tail.
  task automatic receive(input string nm, input logic [39:0] exp);
    int n, len, h, fd, dl;
    logic [39:0] got;
    n = 1;
    tick();
    while (drive_low !== 1'b1 && n < 400) begin tick(); n++; end
    checks++; if (n !== REL_LAT) begin fails++; $display("FAIL %s rel_latency got=%0d exp=%0d", nm, n, REL_LAT); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_in_frame got=%b exp=1", nm, busy); end
    run(1'b1, len);
    checks++; if (len !== 80) begin fails++; $display("FAIL %s resp_low got=%0d exp=80", nm, len); end
    run(1'b0, len);
    checks++; if (len !== 80) begin fails++; $display("FAIL %s resp_high got=%0d exp=80", nm, len); end
    got = '0;
    for (int i = 0; i < 40; i++) begin
      run(1'b1, len);
      checks++; if (len !== 50) begin fails++; $display("FAIL %s bit%0d_low got=%0d exp=50", nm, i, len); end
      run(1'b0, h);
      got[39-i] = (h > 48);
      checks++; if (h !== (exp[39-i] ? 70 : 26)) begin
        fails++; $display("FAIL %s bit%0d_high got=%0d exp=%0d", nm, i, h, exp[39-i] ? 70 : 26);
      end
      if (i == 39) break;
    end
    // The last high run ended on the end-of-frame low, which is the current sample.
    run(1'b1, len);
    checks++; if (len !== 50) begin fails++; $display("FAIL %s end_low got=%0d exp=50", nm, len); end
    checks++; if (frame_done !== 1'b1) begin fails++; $display("FAIL %s frame_done got=%b exp=1", nm, frame_done); end
    checks++; if (got !== exp) begin fails++; $display("FAIL %s frame got=%h exp=%h", nm, got, exp); end
    n = 0; fd = 0; dl = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (n > 0 && frame_done === 1'b1) fd++;
      if (drive_low !== 1'b0) dl++;
      tick();
      n++;
    end
    checks++; if (n !== HOLDOFF) begin fails++; $display("FAIL %s holdoff got=%0d exp=%0d", nm, n, HOLDOFF); end
    checks++; if (fd !== 0 || dl !== 0) begin fails++; $display("FAIL %s hold_quiet got=%0d/%0d exp=0/0", nm, fd, dl); end
  endtask

  task automatic host_start(input int low);
    line_in = 1'b0;
    repeat (low) tick();
    line_in = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; line_in = 1'b1;
    set_data(0, 0, 0, 0);
`ifdef CHECKSUM_CORRUPT_EN
    corrupt_sum = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (drive_low !== 1'b0) begin fails++; $display("FAIL reset_drive_low got=%b exp=0", drive_low); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (err_short !== 1'b0) begin fails++; $display("FAIL reset_err_short got=%b exp=0", err_short); end
  endtask

  task automatic test_basic;
    set_data(45, 0, 23, 0);
    host_start(HOST_LOW);
    receive("basic", 40'h2D_00_17_00_44);
  endtask

  task automatic test_short;
    int errs = 0, dl = 0, bz = 0;
    host_start(START_MIN / 2);
    repeat (200) begin
      tick();
      if (err_short === 1'b1) errs++;
      if (drive_low !== 1'b0) dl++;
      if (busy !== 1'b0) bz++;
    end
    checks++; if (errs !== 1) begin fails++; $display("FAIL short_err_pulses got=%0d exp=1", errs); end
    checks++; if (dl !== 0) begin fails++; $display("FAIL short_drive_low got=%0d exp=0", dl); end
    checks++; if (bz !== 0) begin fails++; $display("FAIL short_busy got=%0d exp=0", bz); end
  endtask

  task automatic test_all_ones;
    set_data(255, 255, 255, 255);
    host_start(HOST_LOW);
    receive("all_ones", 40'hFF_FF_FF_FF_FC);
  endtask

  task automatic test_mid_change;
    set_data(16, 3, 22, 7);
    host_start(HOST_LOW);
    fork
      receive("latch_old", model(16, 3, 22, 7, 0));
      begin repeat (600) tick(); hum = 8'h20; end
    join
    host_start(HOST_LOW);
    receive("latch_new", model(32, 3, 22, 7, 0));
  endtask

  task automatic test_reset_mid_frame;
    int rises = 0, n = 0, h, hd, t, td;
    logic prev;
    set_data(170, 85, 60, 9);
    host_start(HOST_LOW);
    prev = drive_low;
    // Rise 1 is the response low; rise k+2 is the preamble of bit k.
    while (rises < 14 && n < 6000) begin
      tick(); n++;
      if (drive_low === 1'b1 && prev === 1'b0) rises++;
      prev = drive_low;
    end
    checks++; if (rises !== 14) begin fails++; $display("FAIL mid_reach_bit12 got=%0d exp=14", rises); end
    repeat (20) tick();
    checks++; if (drive_low !== 1'b1) begin fails++; $display("FAIL mid_pre_reset_low got=%b exp=1", drive_low); end
    reset = 1'b1;
    tick();
    checks++; if (drive_low !== 1'b0) begin fails++; $display("FAIL mid_reset_drive_low got=%b exp=0", drive_low); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    h = $urandom_range(0, 255); hd = $urandom_range(0, 255);
    t = $urandom_range(0, 255); td = $urandom_range(0, 255);
    set_data(h, hd, t, td);
    host_start(HOST_LOW);
    receive("after_reset", model(h, hd, t, td, 0));
  endtask

  task automatic test_random;
    int h, hd, t, td;
    for (int k = 0; k < 2; k++) begin
      h = $urandom_range(0, 255); hd = $urandom_range(0, 255);
      t = $urandom_range(0, 255); td = $urandom_range(0, 255);
      set_data(h, hd, t, td);
      host_start(HOST_LOW + int'($urandom_range(0, 100)));
      receive("random", model(h, hd, t, td, 0));
    end
  endtask

`ifdef CHECKSUM_CORRUPT_EN
  task automatic test_corrupt;
    set_data(45, 0, 23, 0);
    corrupt_sum = 1'b1;
    host_start(HOST_LOW);
    receive("corrupt", 40'h2D_00_17_00_45);
    corrupt_sum = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_all_ones();
    test_mid_change();
    test_reset_mid_frame();
    test_random();
`ifdef CHECKSUM_CORRUPT_EN
    test_corrupt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
